// File: rtl/arbitro_rr_4.sv
`default_nettype none
// ============================================================================
// Module   : arbitro_rr_4
// Brief    : Four-way round-robin arbiter. The winner is held as a 2-bit index
//            and decoded 2-to-4 into a one-hot grant. The owner keeps the
//            grant while its request stays high. Every output is registered.
// Option   : ARB_TIMEOUT_EN - when defined, a grant is revoked after MAX_HOLD
//            consecutive cycles, timeout pulses for one cycle, and the
//            offender is masked until it drops its request.
// Revision : 1.0 - initial release
// ============================================================================
module arbitro_rr_4 #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned HOLD_W   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_vld,
    output logic       timeout
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [0:0] c_ST_IDLE   = 1'b0;
    localparam logic [0:0] c_ST_GRANT  = 1'b1;
    // Pointer starts at the last slot so requester 0 is scanned first.
    localparam logic [1:0] c_PTR_RESET = 2'b11;

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    logic [0:0] state_q,   state_d;
    logic [1:0] ptr_q,     ptr_d;
    logic [1:0] gnt_idx_q, gnt_idx_d;
    logic       gnt_vld_q, gnt_vld_d;
    logic [3:0] gnt_q,     gnt_d;
    logic       timeout_q, timeout_d;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [3:0] w_eff;        // requests eligible to win this cycle
    logic       w_any;        // at least one eligible request
    logic [1:0] w_winner;     // first eligible index in round-robin order
    logic [1:0] w_cand;       // scan candidate
    logic       w_owner_req;  // current owner still requesting
    logic       w_release;    // owner dropped its request while granted
    logic       w_expire;     // owner hit its hold limit while still requesting
    logic [3:0] w_onehot;     // 2-to-4 decode of the next grant index

    assign w_owner_req = req[gnt_idx_q];
    assign w_release   = (state_q == c_ST_GRANT) && !w_owner_req;
    assign w_any       = |w_eff;

`ifdef ARB_TIMEOUT_EN
    // ------------------------------------------------------------------------
    // Hold counter and starvation mask
    // ------------------------------------------------------------------------
    localparam logic [HOLD_W-1:0] c_HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [3:0]        mask_q,     mask_d;

    assign w_eff    = req & ~mask_q;
    // A release on the same edge wins over expiry: w_owner_req must be high.
    assign w_expire = (state_q == c_ST_GRANT) && w_owner_req &&
                      (hold_cnt_q == c_HOLD_LAST);

    // Count grant cycles of the current owner and maintain the mask; a masked
    // requester is freed at the first edge where its request is low.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        mask_d     = mask_q & req;
        if (state_q == c_ST_IDLE) begin
            hold_cnt_d = '0;
        end else if (w_expire) begin
            mask_d[gnt_idx_q] = 1'b1;
            hold_cnt_d        = '0;
        end else if (w_owner_req && (hold_cnt_q != c_HOLD_LAST)) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
        end
    end

    // Register the hold counter and mask.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_q <= '0;
            mask_q     <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            mask_q     <= mask_d;
        end
    end
`else
    // Without the timeout option every request is always eligible and a
    // grant never expires; the hold parameters only feed a legality flag.
    localparam logic c_PARAMS_LEGAL = (MAX_HOLD >= 2) && (MAX_HOLD <= (1 << HOLD_W));

    logic w_unused_params;

    assign w_eff           = req;
    assign w_expire        = 1'b0;
    assign w_unused_params = c_PARAMS_LEGAL;
`endif

    // Scan ptr+1, ptr+2, ptr+3, ptr; walking backwards lets the earliest
    // slot in scan order overwrite the later ones.
    always_comb begin
        w_winner = ptr_q;
        w_cand   = ptr_q;
        for (int k = 4; k >= 1; k--) begin
            w_cand = ptr_q + 2'(k);
            if (w_eff[w_cand]) begin
                w_winner = w_cand;
            end
        end
    end

    // ------------------------------------------------------------------------
    // 2-to-4 decoder for the registered one-hot grant
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < 4; gi++) begin : g_decode
        assign w_onehot[gi] = (gnt_idx_d == 2'(gi));
    end

    assign gnt_d = w_onehot & {4{gnt_vld_d}};

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------

    // State register plus registered outputs and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= c_ST_IDLE;
            ptr_q     <= c_PTR_RESET;
            gnt_idx_q <= 2'b00;
            gnt_vld_q <= 1'b0;
            gnt_q     <= 4'b0000;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_idx_q <= gnt_idx_d;
            gnt_vld_q <= gnt_vld_d;
            gnt_q     <= gnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Next state: grant from IDLE when anyone is eligible; every exit from
    // GRANT passes through IDLE so owners are separated by an empty cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE: begin
                if (w_any) begin
                    state_d = c_ST_GRANT;
                end
            end
            c_ST_GRANT: begin
                if (w_release || w_expire) begin
                    state_d = c_ST_IDLE;
                end
            end
        endcase
    end

    // Next output values; the index holds its last value when idle, and the
    // winner becomes the pointer so it drops to lowest priority next time.
    always_comb begin
        gnt_idx_d = gnt_idx_q;
        gnt_vld_d = 1'b0;
        timeout_d = 1'b0;
        ptr_d     = ptr_q;
        case (state_q)
            c_ST_IDLE: begin
                if (w_any) begin
                    gnt_idx_d = w_winner;
                    gnt_vld_d = 1'b1;
                    ptr_d     = w_winner;
                end
            end
            c_ST_GRANT: begin
                if (w_release) begin
                    gnt_vld_d = 1'b0;
                end else if (w_expire) begin
                    timeout_d = 1'b1;
                end else begin
                    gnt_vld_d = 1'b1;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign gnt     = gnt_q;
    assign gnt_idx = gnt_idx_q;
    assign gnt_vld = gnt_vld_q;
    assign timeout = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_arbitro_rr_4.sv
`default_nettype none
// ============================================================================
// Module   : tb_arbitro_rr_4
// Brief    : Directed bench for arbitro_rr_4. Each step drives rst/req for
//            one cycle, pushes the outputs expected after the next rising
//            edge onto a queue, then pops and compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arbitro_rr_4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_vld;
    logic       timeout;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] idx;
        logic       vld;
        logic       to;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   n_vec;
    int   n_err;

    arbitro_rr_4 #(
        .MAX_HOLD (4),
        .HOLD_W   (5)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_front();
        exp_t e;
        n_vec++;
        assert (sb.size() > 0) else begin
            n_err++;
            $error("FAIL scoreboard_empty: got 0 entries, required 1");
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_vec++;
            assert (gnt === e.gnt) else begin
                n_err++;
                $error("FAIL %s gnt: got %b, required %b", e.tag, gnt, e.gnt);
            end
            n_vec++;
            assert (gnt_idx === e.idx) else begin
                n_err++;
                $error("FAIL %s gnt_idx: got %0d, required %0d", e.tag, gnt_idx, e.idx);
            end
            n_vec++;
            assert (gnt_vld === e.vld) else begin
                n_err++;
                $error("FAIL %s gnt_vld: got %b, required %b", e.tag, gnt_vld, e.vld);
            end
            n_vec++;
            assert (timeout === e.to) else begin
                n_err++;
                $error("FAIL %s timeout: got %b, required %b", e.tag, timeout, e.to);
            end
        end
    endtask

    // Drive one cycle of stimulus and check the outputs after the next edge.
    task automatic step(input logic r, input logic [3:0] rq,
                        input logic [3:0] eg, input logic [1:0] ei,
                        input logic et, input string tag);
        exp_t e;
        rst   = r;
        req   = rq;
        e.gnt = eg;
        e.idx = ei;
        e.vld = (eg != 4'b0000);
        e.to  = et;
        e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_front();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        req   = 4'b0000;

        // Reset with everyone requesting, then release: requester 0 first.
        step(1, 4'b1111, 4'b0000, 2'd0, 0, "reset");
        step(1, 4'b1111, 4'b0000, 2'd0, 0, "reset_hold");
        step(0, 4'b1111, 4'b0001, 2'd0, 0, "first_grant");

        // Rotation 0,1,2,3,0 with one empty cycle between owners.
        step(0, 4'b1111, 4'b0001, 2'd0, 0, "own0_hold");
        step(0, 4'b1111, 4'b0001, 2'd0, 0, "own0_hold");
        step(0, 4'b1110, 4'b0000, 2'd0, 0, "own0_release");
        step(0, 4'b1111, 4'b0010, 2'd1, 0, "own1_grant");
        step(0, 4'b1111, 4'b0010, 2'd1, 0, "own1_hold");
        step(0, 4'b1111, 4'b0010, 2'd1, 0, "own1_hold");
        step(0, 4'b1101, 4'b0000, 2'd1, 0, "own1_release");
        step(0, 4'b1111, 4'b0100, 2'd2, 0, "own2_grant");
        step(0, 4'b1111, 4'b0100, 2'd2, 0, "own2_hold");
        step(0, 4'b1111, 4'b0100, 2'd2, 0, "own2_hold");
        step(0, 4'b1011, 4'b0000, 2'd2, 0, "own2_release");
        step(0, 4'b1111, 4'b1000, 2'd3, 0, "own3_grant");
        step(0, 4'b1111, 4'b1000, 2'd3, 0, "own3_hold");
        step(0, 4'b1111, 4'b1000, 2'd3, 0, "own3_hold");
        step(0, 4'b0111, 4'b0000, 2'd3, 0, "own3_release");
        step(0, 4'b1111, 4'b0001, 2'd0, 0, "wrap_grant0");

        // Reset mid-grant clears outputs and the pointer.
        step(1, 4'b1111, 4'b0000, 2'd0, 0, "mid_reset");
        step(0, 4'b1111, 4'b0001, 2'd0, 0, "post_reset_grant0");
        step(0, 4'b0000, 4'b0000, 2'd0, 0, "post_reset_release");

        // Lone requester 2: grant, release, re-grant.
        step(0, 4'b0100, 4'b0100, 2'd2, 0, "solo2_grant");
        step(0, 4'b0100, 4'b0100, 2'd2, 0, "solo2_hold");
        step(0, 4'b0000, 4'b0000, 2'd2, 0, "solo2_release");
        step(0, 4'b0100, 4'b0100, 2'd2, 0, "solo2_regrant");
        step(0, 4'b0000, 4'b0000, 2'd2, 0, "solo2_release2");

        // Owner 1 ignores req[3] toggling; release on the 4th grant cycle
        // also beats a timeout; then ptr=1 scan picks 3 over 0.
        step(0, 4'b0010, 4'b0010, 2'd1, 0, "own1b_grant");
        step(0, 4'b1010, 4'b0010, 2'd1, 0, "own1b_req3_up");
        step(0, 4'b0010, 4'b0010, 2'd1, 0, "own1b_req3_down");
        step(0, 4'b1010, 4'b0010, 2'd1, 0, "own1b_req3_up2");
        step(0, 4'b1001, 4'b0000, 2'd1, 0, "own1b_release");
        step(0, 4'b1001, 4'b1000, 2'd3, 0, "scan_after1_pick3");
        step(0, 4'b0000, 4'b0000, 2'd3, 0, "own3b_release");

`ifdef ARB_TIMEOUT_EN
        // Lone requester 0 holds: 4 grant cycles, timeout pulse, masked.
        step(0, 4'b0001, 4'b0001, 2'd0, 0, "to0_grant");
        step(0, 4'b0001, 4'b0001, 2'd0, 0, "to0_hold1");
        step(0, 4'b0001, 4'b0001, 2'd0, 0, "to0_hold2");
        step(0, 4'b0001, 4'b0001, 2'd0, 0, "to0_hold3");
        step(0, 4'b0001, 4'b0000, 2'd0, 1, "to0_timeout");
        step(0, 4'b0001, 4'b0000, 2'd0, 0, "to0_masked");
        step(0, 4'b0001, 4'b0000, 2'd0, 0, "to0_masked2");
        step(0, 4'b0000, 4'b0000, 2'd0, 0, "to0_drop");
        step(0, 4'b0001, 4'b0001, 2'd0, 0, "to0_regrant");
        step(0, 4'b0000, 4'b0000, 2'd0, 0, "to0_release");

        // Two persistent requesters each time out, then both stay masked.
        step(1, 4'b0011, 4'b0000, 2'd0, 0, "to01_reset");
        step(0, 4'b0011, 4'b0001, 2'd0, 0, "to01_grant0");
        step(0, 4'b0011, 4'b0001, 2'd0, 0, "to01_hold0");
        step(0, 4'b0011, 4'b0001, 2'd0, 0, "to01_hold0");
        step(0, 4'b0011, 4'b0001, 2'd0, 0, "to01_hold0");
        step(0, 4'b0011, 4'b0000, 2'd0, 1, "to01_timeout0");
        step(0, 4'b0011, 4'b0010, 2'd1, 0, "to01_grant1");
        step(0, 4'b0011, 4'b0010, 2'd1, 0, "to01_hold1");
        step(0, 4'b0011, 4'b0010, 2'd1, 0, "to01_hold1");
        step(0, 4'b0011, 4'b0010, 2'd1, 0, "to01_hold1");
        step(0, 4'b0011, 4'b0000, 2'd1, 1, "to01_timeout1");
        step(0, 4'b0011, 4'b0000, 2'd1, 0, "to01_both_masked");
        step(0, 4'b0011, 4'b0000, 2'd1, 0, "to01_both_masked2");
        step(0, 4'b0010, 4'b0000, 2'd1, 0, "to01_drop0");
        step(0, 4'b0011, 4'b0001, 2'd0, 0, "to01_regrant0");
        step(0, 4'b0000, 4'b0000, 2'd0, 0, "to01_release");
`else
        // Without the timeout option a grant is held indefinitely.
        step(0, 4'b0001, 4'b0001, 2'd0, 0, "hold0_grant");
        for (int i = 0; i < 6; i++) begin
            step(0, 4'b0001, 4'b0001, 2'd0, 0, "hold0_no_timeout");
        end
        step(0, 4'b0000, 4'b0000, 2'd0, 0, "hold0_release");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
